uart_tx: RTL



---
 rtl/uart_tx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional parity,
// one or two stop bits, bit timing taken from an oversampled baud tick enable.
module uart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int TW = $clog2(OVERSAMPLE * 2);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] BIT_TERM  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_TERM = (STOP_BITS == 2) ? TW'(2 * OVERSAMPLE - 1)
                                                           : TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam bit            PAR_EN    = (PARITY == 1) || (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [TW-1:0]        term_s;
    logic                 last_s;

    // Even parity is the XOR of the data; odd inverts it. Unsupported codes fall back to even,
    // which is harmless because the parity bit is never sent when PAR_EN is clear.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        logic x;
        x = ^d;
        if (PARITY == 2) begin
            parity_of = ~x;
        end else begin
            parity_of = x;
        end
    endfunction

    assign term_s = (state_q == ST_STOP) ? STOP_TERM : BIT_TERM;
    assign last_s = baud_tick && (tick_q == term_s);

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        if ((state_q != ST_IDLE) && baud_tick) begin
            tick_d = last_s ? {TW{1'b0}} : tick_q + TW'(1);
        end else begin
            tick_d = tick_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    shift_d = data_in;
                    par_d   = parity_of(data_in);
                    tick_d  = {TW{1'b0}};
                    bit_d   = {BW{1'b0}};
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (last_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = {BW{1'b0}};
                        state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (last_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx is registered, so it is decoded from the state being entered
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tick_q  <= {TW{1'b0}};
            bit_q   <= {BW{1'b0}};
            shift_q <= {DATA_BITS{1'b0}};
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
